// File: rtl/fifo_shadow_checker.sv
// Passive shadow scoreboard for a ready/valid-in, valid/yumi-out FIFO.
// Mirrors the queue contents and flags reset, data and protocol errors plus occupancy coverage.
module fifo_shadow_checker #(
  parameter int unsigned WIDTH_P = 8,
  parameter int unsigned CAP_P   = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       enq_valid_i,
  input  logic [WIDTH_P-1:0]         enq_data_i,
  input  logic                       enq_ready_i,
  input  logic                       deq_valid_i,
  input  logic [WIDTH_P-1:0]         deq_data_i,
  input  logic                       deq_yumi_i,
  output logic                       res_err_o,
  output logic                       data_err_o,
  output logic                       proto_err_o,
  output logic [$clog2(CAP_P+1)-1:0] count_o,
  output logic [15:0]                err_cnt_o,
  output logic [CAP_P-1:0]           enq_cov_o,
  output logic [CAP_P-1:0]           deq_cov_o,
  output logic [CAP_P-2:0]           both_cov_o
);

  localparam int unsigned CNT_W  = $clog2(CAP_P + 1);
  localparam int unsigned PTR_W  = (CAP_P > 1) ? $clog2(CAP_P) : 1;
  localparam int unsigned BOTH_W = CAP_P - 1;

  typedef enum logic {ARMED, RUN} state_t;

  state_t               state;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [WIDTH_P-1:0]   mem [CAP_P];

  logic                 enq;
  logic                 deq;
  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 res_c;
  logic                 data_c;
  logic                 proto_c;
  logic [CNT_W-1:0]     count_nxt;
  logic [CAP_P-1:0]     enq_cov_nxt;
  logic [CAP_P-1:0]     deq_cov_nxt;
  logic [BOTH_W-1:0]    both_cov_nxt;
  logic [16:0]          err_sum;
  logic [15:0]          err_cnt_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CAP_P - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Event decode, rule checks and next-state for the shadow queue and coverage.
  always_comb begin
    enq          = enq_valid_i & enq_ready_i;
    deq          = deq_valid_i & deq_yumi_i;
    empty        = (count_o == '0);
    full         = (count_o == CNT_W'(CAP_P));
    push         = 1'b0;
    pop          = 1'b0;
    res_c        = 1'b0;
    data_c       = 1'b0;
    proto_c      = 1'b0;
    enq_cov_nxt  = enq_cov_o;
    deq_cov_nxt  = deq_cov_o;
    both_cov_nxt = both_cov_o;

    if (state == ARMED) begin
      res_c = ~enq_ready_i | deq_valid_i;
    end else begin
      pop     = deq & ~empty;
      // A full FIFO may accept a push when the same-cycle yumi frees a slot.
      push    = enq & (~full | deq);
      proto_c = (deq & empty) | (enq & full & ~deq) |
                (deq_valid_i == empty) | (~enq_ready_i & ~full);
      data_c  = pop & (deq_data_i != mem[head]);
      if (push && !pop)
        enq_cov_nxt = enq_cov_o | (CAP_P'(1) << count_o);
      if (pop && !push)
        deq_cov_nxt = deq_cov_o | (CAP_P'(1) << (count_o - CNT_W'(1)));
      if (push && pop && !full)
        both_cov_nxt = both_cov_o | (BOTH_W'(1) << (count_o - CNT_W'(1)));
    end

    count_nxt   = count_o + CNT_W'(push) - CNT_W'(pop);
    err_sum     = {1'b0, err_cnt_o} + 17'(res_c) + 17'(data_c) + 17'(proto_c);
    err_cnt_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // Reset-check FSM, registered outputs and shadow pointers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= ARMED;
      head        <= '0;
      tail        <= '0;
      count_o     <= '0;
      res_err_o   <= 1'b0;
      data_err_o  <= 1'b0;
      proto_err_o <= 1'b0;
      err_cnt_o   <= '0;
      enq_cov_o   <= '0;
      deq_cov_o   <= '0;
      both_cov_o  <= '0;
    end else begin
      state       <= RUN;
      res_err_o   <= res_c;
      data_err_o  <= data_c;
      proto_err_o <= proto_c;
      err_cnt_o   <= err_cnt_nxt;
      count_o     <= count_nxt;
      enq_cov_o   <= enq_cov_nxt;
      deq_cov_o   <= deq_cov_nxt;
      both_cov_o  <= both_cov_nxt;
      if (pop)  head <= ptr_inc(head);
      if (push) tail <= ptr_inc(tail);
    end
  end

  // Shadow storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem[tail] <= enq_data_i;
  end

endmodule

// File: tb/tb_fifo_shadow_checker.sv
// Randomized and directed bench for fifo_shadow_checker against a queue-based reference model.
module tb_fifo_shadow_checker;

  localparam int unsigned W   = 8;
  localparam int unsigned CAP = 8;

  logic            clk_i = 1'b0;
  logic            reset_n_i = 1'b0;
  logic            enq_valid_i = 1'b0;
  logic [W-1:0]    enq_data_i = '0;
  logic            enq_ready_i = 1'b0;
  logic            deq_valid_i = 1'b0;
  logic [W-1:0]    deq_data_i = '0;
  logic            deq_yumi_i = 1'b0;
  logic            res_err_o;
  logic            data_err_o;
  logic            proto_err_o;
  logic [3:0]      count_o;
  logic [15:0]     err_cnt_o;
  logic [CAP-1:0]  enq_cov_o;
  logic [CAP-1:0]  deq_cov_o;
  logic [CAP-2:0]  both_cov_o;

  fifo_shadow_checker #(.WIDTH_P(W), .CAP_P(CAP)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .enq_valid_i(enq_valid_i), .enq_data_i(enq_data_i), .enq_ready_i(enq_ready_i),
    .deq_valid_i(deq_valid_i), .deq_data_i(deq_data_i), .deq_yumi_i(deq_yumi_i),
    .res_err_o(res_err_o), .data_err_o(data_err_o), .proto_err_o(proto_err_o),
    .count_o(count_o), .err_cnt_o(err_cnt_o),
    .enq_cov_o(enq_cov_o), .deq_cov_o(deq_cov_o), .both_cov_o(both_cov_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [W-1:0]   mq[$];
  bit             m_armed;
  int             m_err;
  bit [CAP-1:0]   m_enq_cov;
  bit [CAP-1:0]   m_deq_cov;
  bit [CAP-2:0]   m_both_cov;
  bit             e_res, e_data, e_proto;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] head_val();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_armed = 1'b1;
    m_err = 0;
    m_enq_cov = '0;
    m_deq_cov = '0;
    m_both_cov = '0;
    e_res = 1'b0; e_data = 1'b0; e_proto = 1'b0;
  endtask

  // Applies the checker rules to one clock edge using the inputs presented at that edge.
  task automatic model_step(input bit ev, input logic [W-1:0] ed, input bit er,
                            input bit dv, input logic [W-1:0] dd, input bit dy);
    int c;
    bit enq, deq, popped, pushed;
    e_res = 1'b0; e_data = 1'b0; e_proto = 1'b0;
    if (m_armed) begin
      e_res = !er || dv;
      m_armed = 1'b0;
    end else begin
      c = mq.size();
      enq = ev && er;
      deq = dv && dy;
      e_proto = (deq && c == 0) || (enq && c == CAP && !deq) ||
                (dv != (c > 0)) || (!er && c < CAP);
      popped = deq && c > 0;
      pushed = enq && (c < CAP || deq);
      if (popped) begin
        e_data = (dd != mq[0]);
        void'(mq.pop_front());
      end
      if (pushed) mq.push_back(ed);
      if (pushed && !popped) m_enq_cov[c] = 1'b1;
      if (popped && !pushed) m_deq_cov[c-1] = 1'b1;
      if (pushed && popped && c < CAP) m_both_cov[c-1] = 1'b1;
    end
    m_err = m_err + int'(e_res) + int'(e_data) + int'(e_proto);
    if (m_err > 65535) m_err = 65535;
  endtask

  task automatic check_outputs();
    check("res_err",  32'(res_err_o),   32'(e_res));
    check("data_err", 32'(data_err_o),  32'(e_data));
    check("proto_err", 32'(proto_err_o), 32'(e_proto));
    check("count",    32'(count_o),     32'(mq.size()));
    check("err_cnt",  32'(err_cnt_o),   32'(m_err));
    check("enq_cov",  32'(enq_cov_o),   32'(m_enq_cov));
    check("deq_cov",  32'(deq_cov_o),   32'(m_deq_cov));
    check("both_cov", 32'(both_cov_o),  32'(m_both_cov));
  endtask

  task automatic step(input bit ev, input logic [W-1:0] ed, input bit er,
                      input bit dv, input logic [W-1:0] dd, input bit dy);
    enq_valid_i = ev; enq_data_i = ed; enq_ready_i = er;
    deq_valid_i = dv; deq_data_i = dd; deq_yumi_i = dy;
    @(posedge clk_i);
    model_step(ev, ed, er, dv, dd, dy);
    #1;
    check_outputs();
  endtask

  // Legal-looking FIFO outputs for the current model occupancy.
  task automatic idle();
    step(1'b0, '0, mq.size() < CAP, mq.size() > 0, head_val(), 1'b0);
  endtask

  task automatic do_push(input logic [W-1:0] d);
    step(1'b1, d, mq.size() < CAP, mq.size() > 0, head_val(), 1'b0);
  endtask

  task automatic do_pop(input logic [W-1:0] d);
    step(1'b0, '0, mq.size() < CAP, 1'b1, d, 1'b1);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic apply_reset();
    reset_n_i = 1'b0;
    #2;
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_errs",  32'({res_err_o, data_err_o, proto_err_o}), 32'd0);
    check("rst_cnt",   32'(err_cnt_o), 32'd0);
    check("rst_cov",   32'({enq_cov_o, deq_cov_o, both_cov_o}), 32'd0);
    model_reset();
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    bit ev, er, dv, dy;
    logic [W-1:0] dd;
    model_reset();
    #12;

    // Clean reset check, then a failing one with ready low.
    apply_reset();
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("res_ok_count", 32'(count_o), 32'd0);
    apply_reset();
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    check("res_bad_pulse", 32'(res_err_o), 32'd1);
    check("res_bad_cnt", 32'(err_cnt_o), 32'd1);
    idle();

    // Fill 01..08 then drain with matching data.
    apply_reset();
    idle();
    for (int i = 1; i <= 8; i++) do_push(8'(i));
    check("fill_count", 32'(count_o), 32'd8);
    check("fill_cov", 32'(enq_cov_o), 32'hFF);
    for (int i = 1; i <= 8; i++) do_pop(8'(i));
    check("drain_cov", 32'(deq_cov_o), 32'hFF);
    check("drain_errs", 32'(err_cnt_o), 32'd0);

    // Data mismatch on the second pop.
    apply_reset();
    idle();
    for (int i = 0; i < 8; i++) do_push(8'hA0 + 8'(i));
    do_pop(8'hA0);
    do_pop(8'hFF);
    check("bad_pop_data_err", 32'(data_err_o), 32'd1);
    check("bad_pop_count", 32'(count_o), 32'd6);

    // Simultaneous enq+deq at each occupancy 1..7, then at full.
    apply_reset();
    idle();
    for (int k = 1; k <= 7; k++) begin
      do_push(8'(8'h10 + k));
      step(1'b1, 8'(8'h40 + k), 1'b1, 1'b1, head_val(), 1'b1);
      check("both_count", 32'(count_o), 32'(k));
    end
    check("both_cov_all", 32'(both_cov_o), 32'h7F);
    do_push(8'h77);
    step(1'b1, 8'h88, 1'b1, 1'b1, head_val(), 1'b1);
    check("both_full_proto", 32'(proto_err_o), 32'd0);
    check("both_full_count", 32'(count_o), 32'd8);

    // Underflow and overflow handshakes.
    apply_reset();
    idle();
    step(1'b0, '0, 1'b1, 1'b1, 8'h00, 1'b1);
    check("underflow_proto", 32'(proto_err_o), 32'd1);
    check("underflow_count", 32'(count_o), 32'd0);
    for (int i = 0; i < 8; i++) do_push(8'(8'h30 + i));
    step(1'b1, 8'h55, 1'b1, 1'b1, head_val(), 1'b0);
    check("overflow_proto", 32'(proto_err_o), 32'd1);
    check("overflow_count", 32'(count_o), 32'd8);

    // Reset mid-fill at count 5, then the reset check reruns.
    apply_reset();
    idle();
    for (int i = 0; i < 5; i++) do_push(8'(8'hC0 + i));
    check("midfill_count", 32'(count_o), 32'd5);
    @(negedge clk_i);
    apply_reset();
    step(1'b0, '0, 1'b1, 1'b1, '0, 1'b0);
    check("rerun_res_err", 32'(res_err_o), 32'd1);

    // Randomized traffic with occasional protocol faults and resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) apply_reset();
      ev = ($urandom_range(0, 9) < 6);
      dy = $urandom_range(0, 1) == 1;
      er = (mq.size() < CAP) ? 1'b1 : ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 29) == 0) er = ~er;
      dv = (mq.size() > 0);
      if ($urandom_range(0, 29) == 0) dv = ~dv;
      dd = head_val();
      if ($urandom_range(0, 14) == 0) dd = dd ^ (8'h01 << $urandom_range(0, 7));
      step(ev, 8'($urandom), er, dv, dd, dy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
